// File: rtl/mm_arb_pkg.sv
// mm_arb_pkg: shared types and constants for the matrix-engine arbiter.
// Optional watchdog is enabled by defining MM_ARB_TIMEOUT_EN.
package mm_arb_pkg;

  localparam int MM_ARB_MAX_REQ     = 8;
  localparam int MM_ARB_TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mm_arb_state_e;

endpackage

// File: rtl/mm_rr_picker.sv
// mm_rr_picker: combinational round-robin pick. The search starts at ptr and
// wraps modulo NREQ, so NREQ need not be a power of two.
module mm_rr_picker
  import mm_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx,
  output logic            win_vld
);

  // Scan from the farthest slot back to ptr so the slot nearest ptr wins.
  always_comb begin
    int pos;
    pos     = 0;
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    for (int k = NREQ-1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (req[pos]) begin
        win_oh       = '0;
        win_oh[pos]  = 1'b1;
        win_idx      = IW'(pos);
        win_vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mm_engine_arbiter.sv
// mm_engine_arbiter: round-robin owner of a single matrix_mult_process engine.
// Hands the engine to one requester at a time, holds start for the job and
// returns a one-cycle done pulse (or err pulse from the watchdog).
// Define MM_ARB_TIMEOUT_EN to build the RUN-state watchdog.
module mm_engine_arbiter
  import mm_arb_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = MM_ARB_TIMEOUT_DEF
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] sel,
  output logic [NREQ-1:0]         done,
  output logic [NREQ-1:0]         err,
  output logic                    busy,
  output logic                    pe_start,
  input  logic                    pe_done
);

  localparam int IW = $clog2(NREQ);

  mm_arb_state_e   state;
  logic [IW-1:0]   ptr;
  logic [NREQ-1:0] win_oh;
  logic [IW-1:0]   win_idx;
  logic            win_vld;

  mm_rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

`ifdef MM_ARB_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] run_cnt;
  logic        timeout;
  assign timeout = (run_cnt == TO_LAST);

  // RUN-cycle counter: cleared on grant, counts every RUN cycle without pe_done.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                     run_cnt <= '0;
    else if (state == ST_IDLE)        run_cnt <= '0;
    else if (state == ST_RUN && !pe_done && !timeout)
                                      run_cnt <= run_cnt + 32'd1;
  end
`endif

  // Control FSM; every output is a flop. grant is one-hot at sel, so
  // pulsing done/err with grant addresses exactly the owner.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      grant    <= '0;
      sel      <= '0;
      done     <= '0;
      err      <= '0;
      busy     <= 1'b0;
      pe_start <= 1'b0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            grant    <= win_oh;
            sel      <= win_idx;
            pe_start <= 1'b1;
            busy     <= 1'b1;
            ptr      <= (win_idx == IW'(NREQ-1)) ? '0 : win_idx + 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          // pe_done takes priority over a watchdog expiry in the same cycle.
          if (pe_done) begin
            done     <= grant;
            pe_start <= 1'b0;
            state    <= ST_DONE;
          end
`ifdef MM_ARB_TIMEOUT_EN
          else if (timeout) begin
            err      <= grant;
            pe_start <= 1'b0;
            state    <= ST_DONE;
          end
`endif
        end
        ST_DONE: begin
          // sel is left alone so the last owner can still read results.
          grant <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          grant    <= '0;
          busy     <= 1'b0;
          pe_start <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm_engine_arbiter.sv
// Scoreboard bench for mm_engine_arbiter (NREQ=4, TIMEOUT_CYCLES=16).
// Stimulus pushes the expected output snapshot for each output change plus
// the cycle distance from the previous change; the monitor pops and compares
// whenever the sampled outputs change.
module tb_mm_engine_arbiter;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic [3:0] req;
  logic [3:0] grant, done, err;
  logic [1:0] sel;
  logic       busy, pe_start, pe_done;

  mm_engine_arbiter #(.NREQ(4), .TIMEOUT_CYCLES(16)) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .req      (req),
    .grant    (grant),
    .sel      (sel),
    .done     (done),
    .err      (err),
    .busy     (busy),
    .pe_start (pe_start),
    .pe_done  (pe_done)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [3:0] grant;
    logic [3:0] done;
    logic [3:0] err;
    logic [1:0] sel;
    logic       pe_start;
    logic       busy;
  } snap_t;

  typedef struct {
    snap_t s;
    int    dt;   // cycles since previous output change; 0 = not checked
  } exp_t;

  exp_t expq[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic push(input snap_t s, input int dt);
    exp_t e;
    e.s  = s;
    e.dt = dt;
    expq.push_back(e);
  endtask

  function automatic snap_t mk(input logic [3:0] g, input logic [3:0] d,
                               input logic [3:0] e, input logic [1:0] s,
                               input logic ps, input logic b);
    snap_t r;
    r.grant = g; r.done = d; r.err = e; r.sel = s; r.pe_start = ps; r.busy = b;
    return r;
  endfunction

  // Grant event for requester idx.
  task automatic exp_grant(input int idx, input int dt);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    push(mk(oh, 4'b0, 4'b0, 2'(idx), 1'b1, 1'b1), dt);
  endtask

  // Completion pulse after dt cycles, then grant release one cycle later.
  task automatic exp_end(input int idx, input bit is_err, input int dt);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    push(mk(oh, is_err ? 4'b0 : oh, is_err ? oh : 4'b0, 2'(idx), 1'b0, 1'b1), dt);
    push(mk(4'b0, 4'b0, 4'b0, 2'(idx), 1'b0, 1'b0), 1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, expv);
    end
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    tick(2);
    HRESETn = 1'b1;
  endtask

  // Monitor: compare each output change against the scoreboard head.
  initial begin
    snap_t prev, cur;
    exp_t  e;
    int    cyc, last;
    prev = '0; cyc = 0; last = 0;
    forever begin
      @(negedge HCLK);
      cyc++;
      cur = {grant, done, err, sel, pe_start, busy};
      vectors++;
      if (!$onehot0(done | err)) begin
        miscompares++;
        $display("FAIL onehot done|err at cycle %0d: done=%b err=%b", cyc, done, err);
      end
      if (cur !== prev) begin
        vectors++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected change at cycle %0d: got %h", cyc, cur);
        end else begin
          e = expq.pop_front();
          if (cur !== e.s || (e.dt != 0 && (cyc - last) != e.dt)) begin
            miscompares++;
            $display("FAIL event at cycle %0d: got %h after %0d cyc, expected %h after %0d cyc",
                     cyc, cur, cyc - last, e.s, e.dt);
          end
        end
        prev = cur;
        last = cyc;
      end
    end
  end

  initial begin
    req = 4'b0; pe_done = 1'b0; HRESETn = 1'b0;
    tick(1);
    chk("reset grant", grant, 4'b0);
    chk("reset sel", {2'b0, sel}, 4'b0);
    chk("reset done", done, 4'b0);
    chk("reset err", err, 4'b0);
    chk("reset busy", {3'b0, busy}, 4'b0);
    chk("reset pe_start", {3'b0, pe_start}, 4'b0);
    tick(1);
    HRESETn = 1'b1;

    // Single job, pe_done 5 cycles after grant.
    exp_grant(0, 0); exp_end(0, 0, 5);
    req = 4'b0001;
    tick(5); pe_done = 1'b1;
    tick(1); pe_done = 1'b0; req = 4'b0;
    tick(3);

    // Simultaneous requests from ptr=0: 0 then 1, no re-raise.
    do_reset();
    exp_grant(0, 0); exp_end(0, 0, 3);
    exp_grant(1, 1); exp_end(1, 0, 2);
    req = 4'b0011;
    tick(3); pe_done = 1'b1;
    tick(1); pe_done = 1'b0; req = 4'b0010;
    tick(3); pe_done = 1'b1;
    tick(1); pe_done = 1'b0; req = 4'b0;
    tick(2);

    // Minimum job on idx 2 (pe_done in first RUN cycle) moves ptr to 3.
    exp_grant(2, 0); exp_end(2, 0, 1);
    req = 4'b0100;
    tick(1); pe_done = 1'b1;
    tick(1); pe_done = 1'b0; req = 4'b0;
    tick(2);

    // ptr=3 with req=1001: idx 3, wrap, then idx 0.
    exp_grant(3, 0); exp_end(3, 0, 2);
    exp_grant(0, 1); exp_end(0, 0, 1);
    req = 4'b1001;
    tick(2); pe_done = 1'b1;
    tick(1); pe_done = 1'b0; req = 4'b0001;
    tick(2); pe_done = 1'b1;
    tick(1); pe_done = 1'b0; req = 4'b0;
    tick(2);

    // req dropped mid-RUN still completes; pe_done in IDLE does nothing.
    exp_grant(1, 0); exp_end(1, 0, 4);
    req = 4'b0010;
    tick(2); req = 4'b0;
    tick(2); pe_done = 1'b1;
    tick(1); pe_done = 1'b0;
    tick(3); pe_done = 1'b1;
    tick(1); pe_done = 1'b0;
    tick(2);
    chk("idle grant", grant, 4'b0);
    chk("idle sel kept", {2'b0, sel}, 4'd1);
    chk("idle busy/pe_start", {2'b0, busy, pe_start}, 4'b0);
    chk("idle done", done, 4'b0);

    // Reset mid-RUN, then pending req=1100 re-arbitrated from ptr=0.
    exp_grant(2, 0);
    push(mk(4'b0, 4'b0, 4'b0, 2'd0, 1'b0, 1'b0), 0);
    req = 4'b1100;
    tick(2);
    #2 HRESETn = 1'b0;
    #1;
    chk("async rst grant", grant, 4'b0);
    chk("async rst sel", {2'b0, sel}, 4'b0);
    chk("async rst busy/pe_start", {2'b0, busy, pe_start}, 4'b0);
    chk("async rst done|err", done | err, 4'b0);
    tick(2);
    exp_grant(2, 0); exp_end(2, 0, 2);
    exp_grant(3, 1); exp_end(3, 0, 1);
    HRESETn = 1'b1;
    tick(2); pe_done = 1'b1;
    tick(1); pe_done = 1'b0; req = 4'b1000;
    tick(2); pe_done = 1'b1;
    tick(1); pe_done = 1'b0; req = 4'b0;
    tick(2);

`ifdef MM_ARB_TIMEOUT_EN
    // Watchdog expiry after 16 RUN cycles, then pe_done on the expiry cycle.
    exp_grant(0, 0); exp_end(0, 1, 16);
    req = 4'b0001;
    tick(17); req = 4'b0;
    tick(2);
    exp_grant(1, 0); exp_end(1, 0, 16);
    req = 4'b0010;
    tick(16); pe_done = 1'b1;
    tick(1); pe_done = 1'b0; req = 4'b0;
    tick(2);
`endif

    tick(4);
    vectors++;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: %0d events never seen, expected 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
